add_seq_ctrl: RTL and testbench

Multi-cycle sequencer for 64-bit add/subtract. It time-shares one narrow ripple-carry slice adder over consecutive cycles, which replaces the wide carry-select adder where area matters more than latency. Operands are accepted on a valid/ready handshake. The controller walks the slices LSB-first with a registered inter-slice carry and presents the result (sum, carry-out, signed overflow) on a held valid/ready output.

---
 rtl/add_seq_ctrl_pkg.sv | 18 +
 rtl/add_seq_ctrl_if.sv | 29 ++
 rtl/add_seq_ctrl_add_slice.sv | 26 ++
 rtl/add_seq_ctrl.sv | 114 +++++++++++
 tb/tb_add_seq_ctrl.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/add_seq_ctrl_pkg.sv
// Shared types and defaults for the multi-cycle slice-sequenced adder.
package add_seq_pkg;

    localparam int unsigned DATA_W_DEF  = 64;
    localparam int unsigned SLICE_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Width of the slice index; a single-slice configuration still needs one bit.
    function automatic int unsigned idx_w(input int unsigned nslice);
        return (nslice > 1) ? $clog2(nslice) : 1;
    endfunction

endpackage

// File: rtl/add_seq_ctrl_if.sv
// Operand request / result handshake bundle for add_seq_ctrl.
interface add_seq_ctrl_if
    import add_seq_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              c_in;
    logic              sub;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] sum;
    logic              c_out;
    logic              ovf;
    logic              busy;

    modport master (
        output in_valid, a, b, c_in, sub, out_ready,
        input  in_ready, out_valid, sum, c_out, ovf, busy
    );

    modport slave (
        input  in_valid, a, b, c_in, sub, out_ready,
        output in_ready, out_valid, sum, c_out, ovf, busy
    );
endinterface

// File: rtl/add_seq_ctrl_add_slice.sv
// Combinational W-bit ripple-carry adder shared across all slice steps.
module add_slice #(
    parameter int unsigned W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         c_in,
    output logic [W-1:0] sum,
    output logic         c_out
);
    logic [W-1:0] s;
    logic         c;

    // Bit-serial ripple chain, LSB first.
    always_comb begin
        s = '0;
        c = c_in;
        for (int i = 0; i < int'(W); i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
    end

    assign sum   = s;
    assign c_out = c;
endmodule

// File: rtl/add_seq_ctrl.sv
// Multi-cycle 64-bit add/subtract: walks one shared slice adder LSB-first
// with a registered inter-slice carry. DATA_W must be a multiple of SLICE_W.
module add_seq_ctrl
    import add_seq_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned SLICE_W = SLICE_W_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    add_seq_ctrl_if.slave bus
);
    localparam int unsigned NSLICE = DATA_W / SLICE_W;
    localparam int unsigned IDX_W  = idx_w(NSLICE);

    state_t             state, state_nx;
    logic               load, step, last;
    logic [DATA_W-1:0]  op_a, op_b, sum_q;
    logic               carry, c_out_q, ovf_q;
    logic [IDX_W-1:0]   idx;
    logic               in_ready_q, out_valid_q, busy_q;
    logic [31:0]        sl_base;
    logic [SLICE_W-1:0] sl_a, sl_b, sl_sum;
    logic               sl_co;

    // Operand slice selection for the current step.
    assign last    = (idx == IDX_W'(NSLICE - 1));
    assign sl_base = 32'(idx) * SLICE_W;
    assign sl_a    = op_a[sl_base +: SLICE_W];
    assign sl_b    = op_b[sl_base +: SLICE_W];

    add_slice #(.W(SLICE_W)) u_slice (
        .a     (sl_a),
        .b     (sl_b),
        .c_in  (carry),
        .sum   (sl_sum),
        .c_out (sl_co)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    // Next-state and datapath enables.
    always_comb begin
        state_nx = state;
        load     = 1'b0;
        step     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    load     = 1'b1;
                    state_nx = ST_RUN;
                end
            end
            ST_RUN: begin
                step = 1'b1;
                if (last) state_nx = ST_DONE;
            end
            ST_DONE: begin
                if (bus.out_ready) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Operand latch and per-slice accumulation of sum, carry and flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a    <= '0;
            op_b    <= '0;
            carry   <= 1'b0;
            idx     <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (load) begin
            op_a  <= bus.a;
            op_b  <= bus.sub ? ~bus.b : bus.b;
            carry <= bus.sub ? 1'b1 : bus.c_in;
            idx   <= '0;
        end else if (step) begin
            sum_q[sl_base +: SLICE_W] <= sl_sum;
            carry <= sl_co;
            idx   <= idx + IDX_W'(1);
            if (last) begin
                c_out_q <= sl_co;
                ovf_q   <= op_a[DATA_W-1] ^ op_b[DATA_W-1] ^ sl_sum[SLICE_W-1] ^ sl_co;
            end
        end
    end

    // Handshake/status flags registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            in_ready_q  <= (state_nx == ST_IDLE);
            out_valid_q <= (state_nx == ST_DONE);
            busy_q      <= (state_nx == ST_RUN);
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.sum       = sum_q;
    assign bus.c_out     = c_out_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_add_seq_ctrl.sv
// Directed bench for add_seq_ctrl: default 16-bit slices plus an 8-bit-slice instance.
module tb_add_seq_ctrl;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    add_seq_ctrl_if #(.DATA_W(64)) bus0 ();
    add_seq_ctrl_if #(.DATA_W(64)) bus8 ();

    add_seq_ctrl #(.DATA_W(64), .SLICE_W(16)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.slave)
    );

    add_seq_ctrl #(.DATA_W(64), .SLICE_W(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
        end
    endtask

    // One full operation on the 16-bit-slice instance, with latency check.
    task automatic run_op(input string tag, input logic [63:0] ta, input logic [63:0] tb_v,
                          input logic tcin, input logic tsub, input logic [63:0] esum,
                          input logic ec, input logic eo);
        int lat;
        check({tag, " in_ready"}, 64'(bus0.in_ready), 64'd1);
        bus0.a = ta; bus0.b = tb_v; bus0.c_in = tcin; bus0.sub = tsub;
        bus0.in_valid = 1'b1;
        @(posedge clk); #1;
        bus0.in_valid = 1'b0;
        lat = 0;
        while (!bus0.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'd4);
        check({tag, " sum"}, bus0.sum, esum);
        check({tag, " c_out"}, 64'(bus0.c_out), 64'(ec));
        check({tag, " ovf"}, 64'(bus0.ovf), 64'(eo));
        bus0.out_ready = 1'b1;
        @(posedge clk); #1;
        bus0.out_ready = 1'b0;
        check({tag, " out_valid drop"}, 64'(bus0.out_valid), 64'd0);
    endtask

    initial begin
        int lat;
        int bcnt;
        int seen;
        errors = 0;
        checks = 0;
        rst_n = 1'b0;
        bus0.in_valid = 1'b0; bus0.a = '0; bus0.b = '0; bus0.c_in = 1'b0;
        bus0.sub = 1'b0; bus0.out_ready = 1'b0;
        bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.c_in = 1'b0;
        bus8.sub = 1'b0; bus8.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst sum", bus0.sum, 64'd0);
        check("rst c_out", 64'(bus0.c_out), 64'd0);
        check("rst ovf", 64'(bus0.ovf), 64'd0);
        check("rst out_valid", 64'(bus0.out_valid), 64'd0);
        check("rst busy", 64'(bus0.busy), 64'd0);
        check("rst in_ready", 64'(bus0.in_ready), 64'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0);
        run_op("slice carry", 64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b0,
               64'h0000_0000_0001_0000, 1'b0, 1'b0);
        run_op("cin only", 64'd0, 64'd0, 1'b1, 1'b0, 64'd1, 1'b0, 1'b0);
        run_op("sub borrow", 64'd5, 64'd7, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
        run_op("add ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
               64'h8000_0000_0000_0000, 1'b0, 1'b1);
        run_op("sub noborrow", 64'd7, 64'd5, 1'b0, 1'b1, 64'd2, 1'b1, 1'b0);
        run_op("sub ovf", 64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1,
               64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);

        // Backpressure: result held in DONE while a new request waits.
        bus0.a = 64'd10; bus0.b = 64'd20; bus0.c_in = 1'b0; bus0.sub = 1'b0;
        bus0.in_valid = 1'b1;
        @(posedge clk); #1;
        bus0.a = 64'd100; bus0.b = 64'd23;
        lat = 0;
        while (!bus0.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("bp first latency", 64'(lat), 64'd4);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp hold sum", bus0.sum, 64'd30);
            check("bp hold in_ready", 64'(bus0.in_ready), 64'd0);
            check("bp hold out_valid", 64'(bus0.out_valid), 64'd1);
        end
        bus0.out_ready = 1'b1;
        @(posedge clk); #1;
        bus0.out_ready = 1'b0;
        check("bp release in_ready", 64'(bus0.in_ready), 64'd1);
        check("bp release out_valid", 64'(bus0.out_valid), 64'd0);
        @(posedge clk); #1;
        bus0.in_valid = 1'b0;
        lat = 0;
        while (!bus0.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("bp queued latency", 64'(lat), 64'd4);
        check("bp queued sum", bus0.sum, 64'd123);
        bus0.out_ready = 1'b1;
        @(posedge clk); #1;
        bus0.out_ready = 1'b0;

        // Reset while the slice index is 2.
        bus0.a = 64'd1000; bus0.b = 64'd2000; bus0.in_valid = 1'b1;
        @(posedge clk); #1;
        bus0.in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        check("midrun busy", 64'(bus0.busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("midrun rst out_valid", 64'(bus0.out_valid), 64'd0);
        check("midrun rst busy", 64'(bus0.busy), 64'd0);
        check("midrun rst sum", bus0.sum, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bus0.out_valid) seen++;
        end
        check("midrun no out_valid", 64'(seen), 64'd0);
        run_op("after rst", 64'd3, 64'd4, 1'b0, 1'b0, 64'd7, 1'b0, 1'b0);

        // 8-bit slices: same wrap result, eight steps.
        bus8.a = 64'hFFFF_FFFF_FFFF_FFFF; bus8.b = 64'd1; bus8.c_in = 1'b0; bus8.sub = 1'b0;
        bus8.in_valid = 1'b1;
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        lat = 0;
        bcnt = bus8.busy ? 1 : 0;
        while (!bus8.out_valid && lat < 30) begin
            @(posedge clk); #1;
            lat++;
            if (bus8.busy) bcnt++;
        end
        check("s8 latency", 64'(lat), 64'd8);
        check("s8 busy cycles", 64'(bcnt), 64'd8);
        check("s8 sum", bus8.sum, 64'd0);
        check("s8 c_out", 64'(bus8.c_out), 64'd1);
        check("s8 ovf", 64'(bus8.ovf), 64'd0);
        bus8.out_ready = 1'b1;
        @(posedge clk); #1;
        bus8.out_ready = 1'b0;
        check("s8 in_ready", 64'(bus8.in_ready), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
